// File: rtl/scs8hd_latch_bank_wctl.sv
// Write sequencer for a bank of negative-enable D-latches: round-robin arbitration between two
// requesters, then a timed SETUP / OPEN / HOLD sequence on registered D and GATEN outputs.
module scs8hd_latch_bank_wctl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             A_VALID,
    input  logic [AW-1:0]    A_ADDR,
    input  logic [WIDTH-1:0] A_DATA,
    output logic             A_READY,
    input  logic             B_VALID,
    input  logic [AW-1:0]    B_ADDR,
    input  logic [WIDTH-1:0] B_DATA,
    output logic             B_READY,
    output logic [WIDTH-1:0] LAT_D,
    output logic [DEPTH-1:0] LAT_GATEN,
    output logic             BUSY,
    output logic             ERR,
    output logic [1:0]       DBG_STATE
);

    // Handshake: a transfer happens on a rising edge where VALID & READY; READY is
    // combinational, only offered in IDLE outside reset, and never to both requesters.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_OPEN  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam int MAXC = (SETUP_CYC > PULSE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             prio_q, prio_d;      // 0: A wins a tie, 1: B wins a tie
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic [DEPTH-1:0] gaten_q, gaten_d;
    logic             err_q, err_d;

    logic             idle;
    logic             a_ready, b_ready, xfer, addr_ok;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic [DEPTH-1:0] row_open_n;

    always_comb begin
        idle     = (state_q == S_IDLE);
        a_ready  = idle & ~RESET & A_VALID & (~B_VALID | ~prio_q);
        b_ready  = idle & ~RESET & B_VALID & (~A_VALID |  prio_q);
        xfer     = a_ready | b_ready;
        sel_addr = b_ready ? B_ADDR : A_ADDR;
        sel_data = b_ready ? B_DATA : A_DATA;
        addr_ok  = (32'(sel_addr) < DEPTH);
        row_open_n = '1;
        for (int i = 0; i < DEPTH; i++) begin
            row_open_n[i] = (addr_q != AW'(i));
        end
    end

    // Next-state logic. GATEN is rebuilt every cycle so it can only be low while OPEN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        addr_d  = addr_q;
        lat_d_d = lat_d_q;
        gaten_d = '1;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    prio_d = a_ready;
                    if (addr_ok) begin
                        state_d = S_SETUP;
                        cnt_d   = CW'(SETUP_CYC - 1);
                        addr_d  = sel_addr;
                        lat_d_d = sel_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_OPEN;
                    cnt_d   = CW'(PULSE_CYC - 1);
                    gaten_d = row_open_n;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_OPEN: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    gaten_d = row_open_n;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            lat_d_q <= '0;
            gaten_q <= '1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            lat_d_q <= lat_d_d;
            gaten_q <= gaten_d;
            err_q   <= err_d;
        end
    end

    assign A_READY   = a_ready;
    assign B_READY   = b_ready;
    assign LAT_D     = lat_d_q;
    assign LAT_GATEN = gaten_q;
    assign BUSY      = ~idle;
    assign ERR       = err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_scs8hd_latch_bank_wctl.sv
// Bench for scs8hd_latch_bank_wctl: a default-timing 4-row instance with a latch-bank scoreboard,
// and a 3-row stretched-timing instance for pulse windows and out-of-range addresses.
module tb_scs8hd_latch_bank_wctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_valid, b_valid, a_ready, b_ready, busy, err;
    logic [1:0] a_addr, b_addr, dbg;
    logic [7:0] a_data, b_data, lat_d;
    logic [3:0] gaten;

    logic       a1_valid, b1_valid, a1_ready, b1_ready, busy1, err1;
    logic [1:0] a1_addr, b1_addr, dbg1;
    logic [7:0] a1_data, b1_data, lat_d1;
    logic [2:0] gaten1;

    scs8hd_latch_bank_wctl #(.WIDTH(8), .DEPTH(4), .AW(2),
        .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u0 (
        .CLK(clk), .RESET(rst),
        .A_VALID(a_valid), .A_ADDR(a_addr), .A_DATA(a_data), .A_READY(a_ready),
        .B_VALID(b_valid), .B_ADDR(b_addr), .B_DATA(b_data), .B_READY(b_ready),
        .LAT_D(lat_d), .LAT_GATEN(gaten), .BUSY(busy), .ERR(err), .DBG_STATE(dbg));

    scs8hd_latch_bank_wctl #(.WIDTH(8), .DEPTH(3), .AW(2),
        .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u1 (
        .CLK(clk), .RESET(rst),
        .A_VALID(a1_valid), .A_ADDR(a1_addr), .A_DATA(a1_data), .A_READY(a1_ready),
        .B_VALID(b1_valid), .B_ADDR(b1_addr), .B_DATA(b1_data), .B_READY(b1_ready),
        .LAT_D(lat_d1), .LAT_GATEN(gaten1), .BUSY(busy1), .ERR(err1), .DBG_STATE(dbg1));

    int checks = 0;
    int errors = 0;

    // Scoreboard for u0: {row, data} pushed at each expected transfer, popped when a GATEN pulse ends.
    logic [9:0] exp_q[$];
    logic [7:0] bank_exp[4];
    logic [7:0] bank_obs[4];
    bit         mon_en   = 1'b0;
    bit         in_pulse = 1'b0;
    logic [1:0] p_row, low_idx;
    logic [7:0] p_data;
    logic [9:0] sb_e;
    int         p_len, zeros;

    always @(negedge clk) begin
        if (mon_en) begin
            zeros   = 0;
            low_idx = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (gaten[i] === 1'b0) begin
                    zeros++;
                    low_idx = 2'(i);
                end
            end
            checks++;
            if (zeros > 1 || $isunknown(gaten)) begin
                errors++;
                $display("FAIL gaten_one_low: got %b required at most one low bit", gaten);
            end
            checks++;
            if (a_ready === 1'b1 && b_ready === 1'b1) begin
                errors++;
                $display("FAIL ready_exclusive: got A=%b B=%b required not both", a_ready, b_ready);
            end
            if (zeros == 1) begin
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    p_row    = low_idx;
                    p_data   = lat_d;
                    p_len    = 0;
                end else begin
                    checks++;
                    if (low_idx !== p_row || lat_d !== p_data) begin
                        errors++;
                        $display("FAIL pulse_stable: got row %0d data %h required row %0d data %h",
                                 low_idx, lat_d, p_row, p_data);
                    end
                end
                p_len++;
                bank_obs[low_idx] = lat_d;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                checks++;
                if (p_len != 1) begin
                    errors++;
                    $display("FAIL pulse_len: got %0d required 1", p_len);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_write: got row %0d data %h required none", p_row, p_data);
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({p_row, p_data} !== sb_e) begin
                        errors++;
                        $display("FAIL sb_write: got row %0d data %h required row %0d data %h",
                                 p_row, p_data, sb_e[9:8], sb_e[7:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a1_valid = 1'b0; b1_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; a1_valid = 1'b1;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if (gaten !== 4'hF || lat_d !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got gaten %b d %h busy %b err %b required 1111 00 0 0",
                     gaten, lat_d, busy, err);
        end
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0 || a1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got A %b B %b A1 %b required 0 0 0", a_ready, b_ready, a1_ready);
        end
        checks++;
        if (gaten1 !== 3'b111 || lat_d1 !== 8'h00 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_u1: got gaten %b d %h busy %b required 111 00 0", gaten1, lat_d1, busy1);
        end
        step();
        a_valid = 1'b0; b_valid = 1'b0; a1_valid = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_single_write();
        logic [3:0] eg[4] = '{4'hF, 4'hB, 4'hF, 4'hF};
        logic       eb[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        a_valid = 1'b1; a_addr = 2'd2; a_data = 8'hA5;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got A %b B %b required 1 0", a_ready, b_ready);
        end
        exp_q.push_back({2'd2, 8'hA5});
        bank_exp[2] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            step();
            a_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (gaten !== eg[k] || busy !== eb[k] || lat_d !== 8'hA5) begin
                errors++;
                $display("FAIL single_seq T+%0d: got gaten %b busy %b d %h required %b %b a5",
                         k + 1, gaten, busy, lat_d, eg[k], eb[k]);
            end
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        a_valid = 1'b1; a_addr = 2'd1; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 2'd3; b_data = 8'h33;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL arb_first: got A %b B %b required 1 0", a_ready, b_ready);
        end
        exp_q.push_back({2'd1, 8'h11});
        bank_exp[1] = 8'h11;
        for (int k = 1; k <= 4; k++) begin
            step();
            a_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (b_ready !== (k == 4)) begin
                errors++;
                $display("FAIL arb_wait T+%0d: got B_READY %b required %b", k, b_ready, (k == 4));
            end
        end
        exp_q.push_back({2'd3, 8'h33});
        bank_exp[3] = 8'h33;
        for (int j = 1; j <= 4; j++) begin
            step();
            b_valid = 1'b0;
            if (j == 4) begin
                a_valid = 1'b1; a_addr = 2'd0; a_data = 8'h44;
                b_valid = 1'b1; b_addr = 2'd1; b_data = 8'h55;
            end
            @(negedge clk);
            checks++;
            if (a_ready !== (j == 4) || b_ready !== 1'b0 || busy !== (j < 4)) begin
                errors++;
                $display("FAIL arb_tie j=%0d: got A %b B %b busy %b required %b 0 %b",
                         j, a_ready, b_ready, busy, (j == 4), (j < 4));
            end
        end
        exp_q.push_back({2'd0, 8'h44});
        bank_exp[0] = 8'h44;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_addr = 2'd3; a_data = 8'h5A;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_accept: got %b required 1", a_ready);
        end
        exp_q.push_back({2'd3, 8'h5A});
        bank_exp[3] = 8'h5A;
        step();
        a_valid = 1'b0;
        step();
        rst = 1'b1;
        a_valid = 1'b1; a_addr = 2'd1; a_data = 8'hC3;
        @(negedge clk);
        checks++;
        if (gaten !== 4'b0111 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_open: got gaten %b ready %b required 0111 0", gaten, a_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (gaten !== 4'hF || busy !== 1'b0 || lat_d !== 8'h00 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got gaten %b busy %b d %h ready %b required 1111 0 00 0",
                     gaten, busy, lat_d, a_ready);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_after_reset: got %b required 1", a_ready);
        end
        exp_q.push_back({2'd1, 8'hC3});
        bank_exp[1] = 8'hC3;
        step();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (lat_d !== 8'hC3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_rewrite: got d %h busy %b required c3 1", lat_d, busy);
        end
        repeat (4) step();
    endtask

    task automatic test_stretched_timing();
        logic [2:0] eg;
        do_reset();
        a1_valid = 1'b1; a1_addr = 2'd0; a1_data = 8'h3C;
        @(negedge clk);
        checks++;
        if (a1_ready !== 1'b1) begin
            errors++;
            $display("FAIL stretch_accept: got %b required 1", a1_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            a1_valid = 1'b0;
            @(negedge clk);
            eg = (k >= 3 && k <= 5) ? 3'b110 : 3'b111;
            checks++;
            if (gaten1 !== eg || busy1 !== (k <= 7) || lat_d1 !== 8'h3C) begin
                errors++;
                $display("FAIL stretch_seq T+%0d: got gaten %b busy %b d %h required %b %b 3c",
                         k, gaten1, busy1, lat_d1, eg, (k <= 7));
            end
        end
    endtask

    task automatic test_bad_addr();
        logic [2:0] eg;
        step();
        b1_valid = 1'b1; b1_addr = 2'd3; b1_data = 8'hFF;
        @(negedge clk);
        checks++;
        if (b1_ready !== 1'b1 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL bad_accept: got ready %b err %b required 1 0", b1_ready, err1);
        end
        step();
        b1_valid = 1'b0;
        a1_valid = 1'b1; a1_addr = 2'd1; a1_data = 8'h77;
        @(negedge clk);
        checks++;
        if (err1 !== 1'b1 || gaten1 !== 3'b111 || lat_d1 !== 8'h3C || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL bad_err: got err %b gaten %b d %h busy %b required 1 111 3c 0",
                     err1, gaten1, lat_d1, busy1);
        end
        checks++;
        if (a1_ready !== 1'b1 || b1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bad_next_ready: got A %b B %b required 1 0", a1_ready, b1_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            a1_valid = 1'b0;
            @(negedge clk);
            eg = (k >= 3 && k <= 5) ? 3'b101 : 3'b111;
            checks++;
            if (err1 !== 1'b0 || b1_ready !== 1'b0 || gaten1 !== eg || lat_d1 !== 8'h77) begin
                errors++;
                $display("FAIL bad_after T+%0d: got err %b B %b gaten %b d %h required 0 0 %b 77",
                         k, err1, b1_ready, gaten1, lat_d1, eg);
            end
        end
    endtask

    task automatic test_random();
        bit         a_pend, b_pend, m_prio, idle, ea, eb;
        int         m_busy, served, cyc;
        do_reset();
        a_pend = 1'b0; b_pend = 1'b0; m_prio = 1'b0;
        m_busy = 0; served = 0; cyc = 0;
        while (served < 1000 && cyc < 30000) begin
            step();
            cyc++;
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1'b1;
                a_addr = 2'($urandom_range(0, 3));
                a_data = 8'($urandom_range(0, 255));
            end else if (a_pend && $urandom_range(0, 19) == 0) begin
                a_pend = 1'b0;
            end
            if (!b_pend && $urandom_range(0, 2) == 0) begin
                b_pend = 1'b1;
                b_addr = 2'($urandom_range(0, 3));
                b_data = 8'($urandom_range(0, 255));
            end else if (b_pend && $urandom_range(0, 19) == 0) begin
                b_pend = 1'b0;
            end
            a_valid = a_pend;
            b_valid = b_pend;
            @(negedge clk);
            idle = (m_busy == 0);
            if (!idle) m_busy--;
            ea = idle && a_valid && (!b_valid || !m_prio);
            eb = idle && b_valid && (!a_valid || m_prio);
            checks++;
            if (a_ready !== ea || b_ready !== eb || busy !== !idle) begin
                errors++;
                $display("FAIL rand_ready cyc %0d: got A %b B %b busy %b required %b %b %b",
                         cyc, a_ready, b_ready, busy, ea, eb, !idle);
            end
            if (ea) begin
                exp_q.push_back({a_addr, a_data});
                bank_exp[a_addr] = a_data;
                m_prio = 1'b1; m_busy = 3; a_pend = 1'b0; served++;
            end else if (eb) begin
                exp_q.push_back({b_addr, b_data});
                bank_exp[b_addr] = b_data;
                m_prio = 1'b0; m_busy = 3; b_pend = 1'b0; served++;
            end
        end
        checks++;
        if (served < 1000) begin
            errors++;
            $display("FAIL rand_timeout: got %0d writes required 1000", served);
        end
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (6) step();
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (bank_obs[r] !== bank_exp[r]) begin
                errors++;
                $display("FAIL bank_row %0d: got %h required %h", r, bank_obs[r], bank_exp[r]);
            end
        end
        checks++;
        if (exp_q.size() != 0 || in_pulse) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending required 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        a1_valid = 1'b0; b1_valid = 1'b0; a1_addr = '0; b1_addr = '0; a1_data = '0; b1_data = '0;
        for (int r = 0; r < 4; r++) begin
            bank_exp[r] = 8'h00;
            bank_obs[r] = 8'h00;
        end
        test_reset();
        test_single_write();
        test_arbitration();
        test_reset_mid();
        test_stretched_timing();
        test_bad_addr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
